// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Purpose  : Time-shares one combinational ALU between a datapath issue slot
//            (requester 0) and an auxiliary sequencer (requester 1). The
//            arbitration is round-robin. The winner's operands are registered
//            and drive the ALU. The result and zero flag come back on a
//            single response channel tagged with the requester id.
// Revision : 1.0  initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 3
) (
    input  logic             CLK,
    input  logic             Reset,      // asynchronous, active-low

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req0_imm,
    input  logic [OP_W-1:0]  req0_op,
    input  logic             req0_srcb,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [WIDTH-1:0] req1_imm,
    input  logic [OP_W-1:0]  req1_op,
    input  logic             req1_srcb,

    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,

    output logic [WIDTH-1:0] alu_read_data1,
    output logic [WIDTH-1:0] alu_read_data2,
    output logic [WIDTH-1:0] alu_extended_immediate,
    output logic [OP_W-1:0]  alu_ALUOp,
    output logic             alu_ALUSrcB,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,

    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] imm_q, imm_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic             srcb_q, srcb_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_id_q, resp_id_d;
    logic [WIDTH-1:0] resp_result_q, resp_result_d;
    logic             resp_zero_q, resp_zero_d;

    logic             grant;
    logic             handshake;

    // Round-robin grant, only meaningful while idle: a lone requester wins,
    // under contention the one that did not win last time goes next.
    always_comb begin
        grant = 1'b0;
        if (state_q == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant = ~last_grant_q;
            end else if (req1_valid) begin
                grant = 1'b1;
            end
        end
    end

    // Ready is also masked by reset, so no handshake can be seen while the
    // block is held in reset.
    assign req0_ready = Reset && (state_q == IDLE) && !grant && req0_valid;
    assign req1_ready = Reset && (state_q == IDLE) &&  grant && req1_valid;
    assign handshake  = req0_ready || req1_ready;

    // Next-state and register-update logic for the IDLE/EXEC/RESP sequence.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        id_d          = id_q;
        a_d           = a_q;
        b_d           = b_q;
        imm_d         = imm_q;
        op_d          = op_q;
        srcb_d        = srcb_q;
        resp_valid_d  = resp_valid_q;
        resp_id_d     = resp_id_q;
        resp_result_d = resp_result_q;
        resp_zero_d   = resp_zero_q;

        case (state_q)
            IDLE: begin
                if (handshake) begin
                    state_d      = EXEC;
                    id_d         = grant;
                    last_grant_d = grant;
                    if (grant) begin
                        a_d    = req1_a;
                        b_d    = req1_b;
                        imm_d  = req1_imm;
                        op_d   = req1_op;
                        srcb_d = req1_srcb;
                    end else begin
                        a_d    = req0_a;
                        b_d    = req0_b;
                        imm_d  = req0_imm;
                        op_d   = req0_op;
                        srcb_d = req0_srcb;
                    end
                end
            end
            EXEC: begin
                // The ALU has had a full cycle on the registered operands.
                state_d       = RESP;
                resp_result_d = alu_result;
                resp_zero_d   = alu_zero;
                resp_id_d     = id_q;
                resp_valid_d  = 1'b1;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            id_q          <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            imm_q         <= '0;
            op_q          <= '0;
            srcb_q        <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= 1'b0;
            resp_result_q <= '0;
            resp_zero_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            id_q          <= id_d;
            a_q           <= a_d;
            b_q           <= b_d;
            imm_q         <= imm_d;
            op_q          <= op_d;
            srcb_q        <= srcb_d;
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
            resp_zero_q   <= resp_zero_d;
        end
    end

    // The ALU sees only registered operands. Its inputs hold still while
    // the block is idle.
    assign alu_read_data1         = a_q;
    assign alu_read_data2         = b_q;
    assign alu_extended_immediate = imm_q;
    assign alu_ALUOp              = op_q;
    assign alu_ALUSrcB            = srcb_q;

    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_result = resp_result_q;
    assign resp_zero   = resp_zero_q;
    assign busy        = (state_q != IDLE);

endmodule
`default_nettype wire

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU between two requesters: requester 0 is the main datapath issue slot, requester 1 is an auxiliary sequencer such as an address or iteration unit.
- Arbitrates round-robin, latches the winner's operands and drives the ALU from registers.
- Captures result and zero at the end of the execute cycle and returns them on one shared response channel tagged with the requester id.

Parameters:
- WIDTH, 32, operand/result width.
- OP_W, 3, ALUOp width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- Reset  in  1  one clock; reset is asynchronous and active-low.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  WIDTH  operand A (read_data1).
- req0_b  in  WIDTH  register operand B (read_data2).
- req0_imm  in  WIDTH  extended immediate.
- req0_op  in  OP_W  ALUOp.
- req0_srcb  in  1  ALUSrcB (1 = use immediate).
- req1_valid, req1_ready, req1_a, req1_b, req1_imm, req1_op, req1_srcb: same as requester 0, for requester 1.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer takes response.
- resp_id  out  1  requester that owns the response.
- resp_result  out  WIDTH  captured ALU result.
- resp_zero  out  1  captured ALU zero flag.
- alu_read_data1  out  WIDTH  to ALU operand A.
- alu_read_data2  out  WIDTH  to ALU operand B.
- alu_extended_immediate  out  WIDTH  to ALU immediate.
- alu_ALUOp  out  OP_W  to ALU opcode.
- alu_ALUSrcB  out  1  to ALU B-source select.
- alu_result  in  WIDTH  from ALU.
- alu_zero  in  1  from ALU.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- States: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values: all registered outputs and operand registers 0, resp_valid 0, resp_id 0, busy 0, last_grant = 1 so requester 0 wins first contention.
- Grant is combinational and computed in IDLE only:
  - only one valid: that requester is granted;
  - both valid: the requester != last_grant is granted;
  - reqN_ready = (state == IDLE) & grant == N & reqN_valid. At most one ready is high per cycle.
- IDLE -> EXEC on handshake. At that edge, latch the winner's a/b/imm/op/srcb into operand registers, save the id, and set last_grant = id.
- ALU ports are driven only from the operand registers, never combinationally from requester inputs. Requesters may change operands after their handshake.
- EXEC lasts exactly one cycle, then moves to RESP. At that edge, capture resp_result = alu_result, resp_zero = alu_zero, resp_id = id, and set resp_valid = 1.
- RESP: hold resp_result/resp_zero/resp_id stable while resp_ready is low. On an edge with resp_ready = 1, clear resp_valid and go to IDLE.
- No request is accepted in EXEC or RESP. Minimum spacing between accepts is 3 cycles. Latency is handshake edge k -> resp_valid high after edge k+1.
- Operand registers keep their last value in IDLE, so the ALU inputs stay static with no spurious toggling.
- Requesters must hold valid until ready. A dropped valid before grant is simply not served.
- resp_ready arriving while a new request is pending in RESP: the response retires, and the pending request is granted in the following IDLE cycle.
- Asserting Reset mid-operation (EXEC or RESP) forces IDLE immediately. The in-flight operation is discarded, no response is produced, and last_grant returns to 1.
- No arithmetic in this block. Widths pass through unchanged.

Test Plan:
- Single op: req0 a=5, b=3, op=001, srcb=0 -> req0_ready for 1 cycle; 2 edges later resp_valid=1, resp_id=0, resp_result=2, resp_zero=0.
- Immediate and zero flag: req1 a=7, imm=7, srcb=1, op=001 -> resp_id=1, result=0, zero=1; alu_ALUSrcB=1 during EXEC.
- Contention fairness: both valid continuously (req0 op=000 1+2, req1 op=011 4|1) with resp_ready=1 -> grants alternate 0,1,0,1; results 3,5,3,5; accepts exactly 3 cycles apart.
- Backpressure: resp_ready=0 for 5 cycles after a response -> resp_result/resp_id stable, req*_ready stays 0, busy=1; release -> next accept one cycle after resp_valid falls.
- Operand independence: change req0_a 1 cycle after its handshake -> alu_read_data1 and result reflect the originally latched value.
- Reset mid-op: deassert Reset (drive low) during EXEC -> resp_valid stays 0, all outputs 0 asynchronously; after release with both valid, requester 0 is granted first.
